div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter TAG_W, default 5: destination-register tag width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: issue strobe from the hazard/issue unit; accepted only while div_ready=1.
REQ-007 Port op_mod, input, 1: 0 = quotient (div), 1 = remainder (mod).
REQ-008 Port op_a, input, WIDTH: dividend.
REQ-009 Port op_b, input, WIDTH: divisor.
REQ-010 Port tag_in, input, TAG_W: destination tag carried with the op.
REQ-011 Port div_ready, output, 1: unit can accept start this cycle.
REQ-012 Port result_v, output, 1: result valid, one-cycle pulse.
REQ-013 Port result, output, WIDTH: quotient or remainder, selected by the captured op_mod.
REQ-014 Port result_tag, output, TAG_W: captured tag_in.
REQ-015 Port div_by_zero, output, 1: qualified by result_v; op_b was 0.

Function
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 div_ready SHALL be 1 in IDLE and in DONE, and 0 in CALC.
REQ-018 start with div_ready=1 in cycle N SHALL capture op_mod, op_a, op_b and tag_in, then enter CALC.
REQ-019 CALC SHALL perform one radix-2 restoring step per cycle for exactly WIDTH cycles, using a counter that counts WIDTH-1 down to 0.
REQ-020 DONE SHALL be entered in cycle N+WIDTH+1, with result_v=1 for exactly that cycle; fixed LATENCY = WIDTH+1 (33 at WIDTH=32), data-independent, so the issue unit's reservation slot is always honored.
REQ-021 In DONE, start=1 SHALL load a new op and go to CALC (back-to-back issue, one result per WIDTH+1 cycles); start=0 SHALL go to IDLE.
REQ-022 start while div_ready=0 SHALL be ignored, with no state change and no captured data altered.
REQ-023 op_b=0 SHALL give quotient all-ones and remainder = op_a, with div_by_zero=1, at the same LATENCY.
REQ-024 result, result_tag and div_by_zero SHALL hold their last values outside result_v cycles.
REQ-025 Arithmetic SHALL be unsigned unless DIV_SIGNED_EN is defined; the partial remainder SHALL be WIDTH+1 bits to hold the subtract borrow.

Reset
REQ-026 reset SHALL asynchronously force state=IDLE, counter=0, div_ready=1, result_v=0, result=0, result_tag=0 and div_by_zero=0.
REQ-027 reset mid-CALC SHALL abort the op, with no result_v pulse afterwards.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: operands SHALL be two's complement, the quotient SHALL truncate toward zero, and the remainder SHALL take the dividend's sign.
REQ-029 With DIV_SIGNED_EN, sign fix-up SHALL be folded into the load and DONE cycles so LATENCY is unchanged.
REQ-030 With DIV_SIGNED_EN, MIN/-1 SHALL give quotient MIN and remainder 0, and by-zero SHALL give quotient -1 and remainder = op_a.
REQ-031 Macro DIV_SIGNED_EN undefined: unsigned only; no sign logic SHALL be synthesized.

Structure
REQ-032 Shared package div_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the LATENCY function of WIDTH, which the issue unit also uses for its op_delay.
REQ-033 Sub-module div_step (combinational, one restoring shift/subtract/select) SHALL be instantiated once inside div_unit.

Verification
REQ-034 WIDTH=32, div 100/7 at cycle 0: result_v at cycle 33, result=14, div_by_zero=0.
REQ-035 mod 100%7: result=2 at cycle 33; div 0xFFFFFFFF/1: result=0xFFFFFFFF.
REQ-036 div 5/0, tag 3: result=0xFFFFFFFF, div_by_zero=1, result_tag=3, at cycle 33.
REQ-037 start at cycle 0, second start at cycle 10 (ignored), third start held in DONE (cycle 33): exactly two results, at cycles 33 and 66, with correct tags.
REQ-038 reset asserted at cycle 12 of CALC: outputs go to reset values immediately, no result_v follows, and div_ready=1.
REQ-039 DIV_SIGNED_EN defined, -7/2: quotient -3 (0xFFFFFFFD), -7 mod 2 = -1; 0x80000000/-1 gives quotient 0x80000000.

Source files
------------

// File: rtl/div_pkg.sv
//==============================================================================
// div_pkg : shared state encoding and latency helper for the divide unit
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } div_state_e;

  // Issue-to-result delay; the issue unit sizes its reservation slot from this.
  function automatic int latency(input int width);
    return width + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/div_if.sv
//==============================================================================
// div_if : issue/result bundle between the issue unit and div_unit
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

interface div_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             start;
  logic             op_mod;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [TAG_W-1:0] tag_in;
  logic             div_ready;
  logic             result_v;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] result_tag;
  logic             div_by_zero;

  modport master (
    output start, op_mod, op_a, op_b, tag_in,
    input  div_ready, result_v, result, result_tag, div_by_zero
  );

  modport slave (
    input  start, op_mod, op_a, op_b, tag_in,
    output div_ready, result_v, result, result_tag, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/div_step.sv
//==============================================================================
// div_step : one combinational radix-2 restoring shift/subtract/select step
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module div_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0] i_rem,
  input  wire logic [WIDTH-1:0] i_quo,
  input  wire logic [WIDTH-1:0] i_dsr,
  output logic      [WIDTH-1:0] o_rem,
  output logic      [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;

  // Top bit of the WIDTH+1 difference is the borrow: set exactly when shift < divisor.
  assign w_shift  = {i_rem, i_quo[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, i_dsr};
  assign w_borrow = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_borrow};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
//==============================================================================
// div_unit : fixed-latency (WIDTH+1) iterative restoring divider with tag.
//            Define DIV_SIGNED_EN for two's-complement operands.
// Rev 1.0 : initial release
//==============================================================================
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input wire logic clk,
  input wire logic reset,
  div_if.slave     bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dsr;
  logic             r_mod;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_result_tag;
  logic             r_dbz;

  logic             w_ready;
  logic             w_accept;
  logic             w_dbz;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_res_fin;

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
`endif

  assign w_ready  = (r_state != ST_CALC);
  assign w_accept = bus.start && w_ready;
  assign w_dbz    = (r_dsr == '0);

  always_comb begin
    w_a_mag = bus.op_a;
    w_b_mag = bus.op_b;
`ifdef DIV_SIGNED_EN
    if (bus.op_a[WIDTH-1]) w_a_mag = -bus.op_a;
    if (bus.op_b[WIDTH-1]) w_b_mag = -bus.op_b;
`endif
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dsr (r_dsr),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Divide-by-zero quotient is forced after sign fix-up so it reads as -1 either way.
  always_comb begin
    w_quo_fin = w_quo_nxt;
    w_rem_fin = w_rem_nxt;
`ifdef DIV_SIGNED_EN
    if (r_neg_q) w_quo_fin = -w_quo_nxt;
    if (r_neg_r) w_rem_fin = -w_rem_nxt;
`endif
    if (w_dbz) w_quo_fin = '1;
    w_res_fin = r_mod ? w_rem_fin : w_quo_fin;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dsr        <= '0;
      r_mod        <= 1'b0;
      r_tag        <= '0;
      r_result     <= '0;
      r_result_tag <= '0;
      r_dbz        <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_state <= ST_CALC;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dsr   <= w_b_mag;
            r_mod   <= bus.op_mod;
            r_tag   <= bus.tag_in;
`ifdef DIV_SIGNED_EN
            r_neg_q <= bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
            r_neg_r <= bus.op_a[WIDTH-1];
`endif
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          if (r_cnt == '0) begin
            r_state      <= ST_DONE;
            r_result     <= w_res_fin;
            r_result_tag <= r_tag;
            r_dbz        <= w_dbz;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.div_ready   = w_ready;
  assign bus.result_v    = (r_state == ST_DONE);
  assign bus.result      = r_result;
  assign bus.result_tag  = r_result_tag;
  assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire
